// File: rtl/alu_serial_port_pkg.sv
// ---------------------------------------------------------------------------
// alu_serial_port_pkg
// Shared definitions for the bit-serial ALU front/back end: default widths,
// FSM state encoding and the beat-count helper.
// ---------------------------------------------------------------------------
package alu_serial_port_pkg;

  localparam int unsigned REG_BITS_DEF = 8;
  localparam int unsigned NSHIFT_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of NSHIFT-bit beats needed to move one operand across the lanes.
  function automatic int unsigned beats(input int unsigned reg_bits,
                                        input int unsigned nshift,
                                        input logic        pair);
    return pair ? (2 * reg_bits) / nshift : reg_bits / nshift;
  endfunction

endpackage

// File: rtl/alu_serial_port_if.sv
// ---------------------------------------------------------------------------
// alu_serial_port_if
// Request/response handshake bundle of alu_serial_port.
//   Request : in_valid, in_ready, in_pair, in_arg1, in_arg2
//   Response: out_valid, out_ready, out_data, out_error
// master = upstream/downstream client, slave = alu_serial_port.
// ---------------------------------------------------------------------------
interface alu_serial_port_if
  import alu_serial_port_pkg::*;
#(
  parameter int unsigned REG_BITS = REG_BITS_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_pair;
  logic [2*REG_BITS-1:0] in_arg1;
  logic [2*REG_BITS-1:0] in_arg2;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*REG_BITS-1:0] out_data;
  logic                  out_error;

  modport master (
    output in_valid, in_pair, in_arg1, in_arg2, out_ready,
    input  in_ready, out_valid, out_data, out_error
  );

  modport slave (
    input  in_valid, in_pair, in_arg1, in_arg2, out_ready,
    output in_ready, out_valid, out_data, out_error
  );
endinterface

// File: rtl/alu_serial_port_serial_shifter.sv
// ---------------------------------------------------------------------------
// serial_shifter
// LANES independent W-bit registers with parallel load and a right shift by
// NSHIFT per cycle; each lane takes its own NSHIFT-bit serial input at the MSB.
//   clk     : clock
//   load_i  : parallel load (wins over shift)
//   shift_i : shift every lane right by NSHIFT
//   par_i   : parallel load value, lane l at [l*W +: W]
//   ser_i   : serial inputs, lane l at [l*NSHIFT +: NSHIFT]
//   q_o     : register contents
// Pure datapath: no reset.
// ---------------------------------------------------------------------------
module serial_shifter #(
  parameter int unsigned W      = 16,
  parameter int unsigned NSHIFT = 2,
  parameter int unsigned LANES  = 1
) (
  input  logic                    clk,
  input  logic                    load_i,
  input  logic                    shift_i,
  input  logic [LANES*W-1:0]      par_i,
  input  logic [LANES*NSHIFT-1:0] ser_i,
  output logic [LANES*W-1:0]      q_o
);
  logic [LANES*W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      q_q <= par_i;
    end else if (shift_i) begin
      for (int l = 0; l < int'(LANES); l++) begin
        q_q[l*W +: W] <= {ser_i[l*NSHIFT +: NSHIFT], q_q[l*W+NSHIFT +: W-NSHIFT]};
      end
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/alu_serial_port.sv
// ---------------------------------------------------------------------------
// alu_serial_port
// Parallel-to-serial front end and serial-to-parallel back end for the
// bit-serial ALU. Operands are streamed LSB-first NSHIFT bits per cycle onto
// alu_data_in1/2 while alu_data_out is collected into a result register.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/in_pair/in_arg1/in_arg2 request,
//                  out_valid/out_ready/out_data/out_error response
//   alu_op_valid : operation in progress (RUN)
//   alu_pair_op  : latched in_pair
//   alu_data_in1 : lane 1 operand bits
//   alu_data_in2 : lane 2 operand bits
//   alu_data_out : result bits from the ALU
//   alu_op_done  : ALU marks the final beat
// ---------------------------------------------------------------------------
module alu_serial_port
  import alu_serial_port_pkg::*;
#(
  parameter int unsigned REG_BITS = REG_BITS_DEF,
  parameter int unsigned NSHIFT   = NSHIFT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  alu_serial_port_if.slave  bus,
  output logic              alu_op_valid,
  output logic              alu_pair_op,
  output logic [NSHIFT-1:0] alu_data_in1,
  output logic [NSHIFT-1:0] alu_data_in2,
  input  logic [NSHIFT-1:0] alu_data_out,
  input  logic              alu_op_done
);
  localparam int unsigned W            = 2 * REG_BITS;
  localparam int unsigned NBEAT_PAIR   = beats(REG_BITS, NSHIFT, 1'b1);
  localparam int unsigned NBEAT_SINGLE = beats(REG_BITS, NSHIFT, 1'b0);
  localparam int unsigned BW           = (NBEAT_PAIR > 1) ? $clog2(NBEAT_PAIR) : 1;

  state_e          state_q;
  logic            pair_q;
  logic            err_q;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   last_beat;
  logic            run;
  logic            done_st;
  logic            accept;
  logic [2*W-1:0]  sh_q;
  logic [W-1:0]    res_q;

  assign run       = (state_q == ST_RUN);
  assign done_st   = (state_q == ST_DONE);
  assign last_beat = pair_q ? BW'(NBEAT_PAIR - 1) : BW'(NBEAT_SINGLE - 1);

  // Ready in IDLE, or in DONE when the result is being taken this cycle, so a
  // waiting request follows the previous one with no bubble.
  assign bus.in_ready = (state_q == ST_IDLE) || (done_st && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand shifters: lane 0 = sh1 (data_in1), lane 1 = sh2 (data_in2).
  serial_shifter #(.W(W), .NSHIFT(NSHIFT), .LANES(2)) u_sh (
    .clk     (clk),
    .load_i  (accept),
    .shift_i (run),
    .par_i   ({bus.in_arg2, bus.in_arg1}),
    .ser_i   ('0),
    .q_o     (sh_q)
  );

  // Result collector: ALU bits enter at the MSB, so after N beats a single
  // result sits in the upper REG_BITS and a pair result fills all W bits.
  serial_shifter #(.W(W), .NSHIFT(NSHIFT), .LANES(1)) u_res (
    .clk     (clk),
    .load_i  (accept),
    .shift_i (run),
    .par_i   ('0),
    .ser_i   (alu_data_out),
    .q_o     (res_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pair_q  <= 1'b0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pair_q  <= bus.in_pair;
            beat_q  <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          beat_q <= beat_q + BW'(1);
          if (alu_op_done) begin
            if (beat_q != last_beat) err_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (beat_q == last_beat) begin
            // ALU never signalled completion: flag it and finish anyway.
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (accept) begin
            pair_q  <= bus.in_pair;
            beat_q  <= '0;
            state_q <= ST_RUN;
          end else if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so they are glitch-free
  // and all read 0 (except in_ready) out of reset.
  assign alu_op_valid  = run;
  assign alu_pair_op   = pair_q;
  assign alu_data_in1  = run ? sh_q[NSHIFT-1:0]   : '0;
  assign alu_data_in2  = run ? sh_q[W +: NSHIFT]  : '0;
  assign bus.out_valid = done_st;
  assign bus.out_error = err_q;
  assign bus.out_data  = !done_st ? '0 :
                         pair_q   ? res_q : {{REG_BITS{1'b0}}, res_q[W-1 -: REG_BITS]};
endmodule
